gp_register_bank: RTL and testbench
===================================

// Module: gp_register_bank
// PURPOSE
//   Parametrised bank of DEPTH general-purpose registers, successor to the single
//   16-bit general-purpose register. One write port with op modes (load/inc/dec/clear),
//   two registered read ports with write-to-read bypass, zero flags and wrap pulse.
//   Sits between the control unit and the ALU; replaces discrete GPR instances.
// PARAMETERS
//   WIDTH     16  data width of each register, bits
//   DEPTH     8   number of registers (>=2)
//   ADDR_W    3   address width, must equal $clog2(DEPTH)
//   RESET_VAL 0   value loaded into every register on reset
// PORTS
//   clk         in   1       rising-edge clock
//   rst         in   1       asynchronous reset, active-low (0 = reset)
//   wr_en       in   1       write-port strobe, sampled at posedge clk
//   wr_op       in   2       00 load data_in, 01 increment, 10 decrement, 11 clear
//   wr_addr     in   ADDR_W  target register
//   data_in     in   WIDTH   load value (used only when wr_op=00)
//   rd_en       in   1       read strobe for both read ports
//   rd_a_addr   in   ADDR_W  read port A address
//   rd_b_addr   in   ADDR_W  read port B address
//   data_out_a  out  WIDTH   registered read data, port A
//   data_out_b  out  WIDTH   registered read data, port B
//   rd_valid    out  1       high one cycle after an accepted rd_en
//   zero_a      out  1       data_out_a == 0
//   zero_b      out  1       data_out_b == 0
//   wrap        out  1       one-cycle pulse: inc from all-ones or dec from zero
// BEHAVIOUR
//   - Reset (rst=0, async, any time): all registers = RESET_VAL; data_out_a/b = 0;
//     rd_valid = 0; wrap = 0; zero_a/b = 1. Deassertion takes effect at next posedge.
//   - Write, posedge with wr_en=1: reg[wr_addr] <= f(wr_op):
//     load = data_in; inc = reg+1 mod 2^WIDTH; dec = reg-1 mod 2^WIDTH; clear = 0.
//     wr_en=0: no register changes; wr_op/wr_addr/data_in ignored.
//   - wrap: registered; =1 in cycle after a write with (inc, reg=all-ones) or
//     (dec, reg=0); =0 otherwise, including load/clear and wr_en=0.
//   - Read, posedge with rd_en=1: data_out_a <= value of reg[rd_a_addr] AFTER this
//     edge's write (bypass: if wr_en and wr_addr==rd_a_addr, use f(wr_op) result);
//     same for port B. Latency 1 cycle; rd_valid <= 1.
//   - rd_en=0: data_out_a/b hold previous value; rd_valid <= 0.
//   - Both ports may address the same register; both return identical data.
//   - zero_a/zero_b are combinational compares of data_out_a/b (track held values).
//   - No illegal states: every wr_op encoding defined; addresses >= DEPTH (when DEPTH
//     not a power of 2) write nothing and read as 0.
//   - Reset asserted mid-write or mid-read discards that operation; no partial update.
// TESTING
//   1 rst=0 for 2 cycles, release; rd_en, rd_a=0, rd_b=7 -> next cycle outputs 0,
//     rd_valid=1, zero_a=zero_b=1, wrap=0.
//   2 wr_en, op=00, addr=3, data_in=16'h3333; next cycle rd_a=3 -> data_out_a=16'h3333
//     one cycle later, zero_a=0; with wr_en=0 and data_in=16'h333F, reg 3 unchanged.
//   3 same-cycle write (addr=5, load 16'hABCD) and read rd_a=rd_b=5 -> both ports show
//     16'hABCD in the following cycle (bypass).
//   4 load reg 2 = 16'hFFFF, then inc reg 2 -> reg 2 = 0, wrap=1 for exactly one cycle;
//     dec reg 2 -> 16'hFFFF, wrap=1; clear reg 2 -> 0, wrap=0.
//   5 load reg 1 = 16'h0001; then dec with rd_a=1 same cycle -> data_out_a=0, zero_a=1.
//   6 pull rst=0 between clock edges while wr_en=1 -> outputs 0 immediately, all regs
//     read back RESET_VAL after release; pending write not applied.

Source files
------------

// File: rtl/gp_register_bank.sv
// Bank of DEPTH general-purpose registers: one op-mode write port,
// two registered read ports with write-to-read bypass, zero flags, wrap pulse.
module gp_register_bank #(
  parameter int                WIDTH     = 16,
  parameter int                DEPTH     = 8,
  parameter int                ADDR_W    = 3,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [1:0]        wr_op,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  data_in,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_a_addr,
  input  logic [ADDR_W-1:0] rd_b_addr,
  output logic [WIDTH-1:0]  data_out_a,
  output logic [WIDTH-1:0]  data_out_b,
  output logic              rd_valid,
  output logic              zero_a,
  output logic              zero_b,
  output logic              wrap
);

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_INC  = 2'b01;
  localparam logic [1:0] OP_DEC  = 2'b10;
  localparam logic [1:0] OP_CLR  = 2'b11;

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  logic [WIDTH-1:0] regs [DEPTH];

  logic             wr_ok;
  logic             rd_a_ok;
  logic             rd_b_ok;
  logic             wr_hit;
  logic [WIDTH-1:0] wr_cur;
  logic [WIDTH-1:0] wr_res;
  logic             wr_wrap;
  logic [WIDTH-1:0] rd_a_val;
  logic [WIDTH-1:0] rd_b_val;

  // Addresses past DEPTH only exist when DEPTH is not a power of two.
  assign wr_ok   = {1'b0, wr_addr}   < DEPTH_L;
  assign rd_a_ok = {1'b0, rd_a_addr} < DEPTH_L;
  assign rd_b_ok = {1'b0, rd_b_addr} < DEPTH_L;

  always_comb begin
    wr_hit  = wr_en && wr_ok;
    wr_cur  = wr_ok ? regs[wr_addr] : '0;
    wr_res  = wr_cur;
    wr_wrap = 1'b0;
    unique case (1'b1)
      (wr_op == OP_LOAD): wr_res = data_in;
      (wr_op == OP_INC): begin
        wr_res  = wr_cur + 1'b1;
        wr_wrap = &wr_cur;
      end
      (wr_op == OP_DEC): begin
        wr_res  = wr_cur - 1'b1;
        wr_wrap = ~|wr_cur;
      end
      (wr_op == OP_CLR): wr_res = '0;
      default: wr_res = wr_cur;
    endcase
    wr_wrap = wr_wrap && wr_hit;
  end

  // Reads observe the value after this edge's write.
  always_comb begin
    rd_a_val = rd_a_ok ? regs[rd_a_addr] : '0;
    rd_b_val = rd_b_ok ? regs[rd_b_addr] : '0;
    if (wr_hit && (wr_addr == rd_a_addr)) rd_a_val = wr_res;
    if (wr_hit && (wr_addr == rd_b_addr)) rd_b_val = wr_res;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= RESET_VAL;
    end else if (wr_hit) begin
      regs[wr_addr] <= wr_res;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_out_a <= '0;
      data_out_b <= '0;
      rd_valid   <= 1'b0;
      wrap       <= 1'b0;
    end else begin
      wrap     <= wr_wrap;
      rd_valid <= rd_en;
      if (rd_en) begin
        data_out_a <= rd_a_val;
        data_out_b <= rd_b_val;
      end
    end
  end

  assign zero_a = ~|data_out_a;
  assign zero_b = ~|data_out_b;

endmodule

// File: tb/tb_gp_register_bank.sv
// Directed bench for gp_register_bank: reset, load/inc/dec/clear,
// bypass, wrap pulse, read hold and asynchronous reset mid-cycle.
module tb_gp_register_bank;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [1:0]  wr_op;
  logic [2:0]  wr_addr;
  logic [15:0] data_in;
  logic        rd_en;
  logic [2:0]  rd_a_addr;
  logic [2:0]  rd_b_addr;
  logic [15:0] data_out_a;
  logic [15:0] data_out_b;
  logic        rd_valid;
  logic        zero_a;
  logic        zero_b;
  logic        wrap;

  int passed = 0;
  int total  = 0;

  gp_register_bank #(
    .WIDTH(16), .DEPTH(8), .ADDR_W(3), .RESET_VAL(16'h0000)
  ) dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_op(wr_op), .wr_addr(wr_addr), .data_in(data_in),
    .rd_en(rd_en), .rd_a_addr(rd_a_addr), .rd_b_addr(rd_b_addr),
    .data_out_a(data_out_a), .data_out_b(data_out_b),
    .rd_valid(rd_valid), .zero_a(zero_a), .zero_b(zero_b), .wrap(wrap)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic wr(input logic en, input logic [1:0] op,
                    input logic [2:0] a, input logic [15:0] d);
    wr_en = en; wr_op = op; wr_addr = a; data_in = d;
  endtask

  task automatic rd(input logic en, input logic [2:0] a, input logic [2:0] b);
    rd_en = en; rd_a_addr = a; rd_b_addr = b;
  endtask

  initial begin
    rst = 1'b0;
    wr(1'b0, 2'b00, 3'd0, 16'h0);
    rd(1'b0, 3'd0, 3'd0);
    tick();
    tick();
    chk("rst_dout_a", data_out_a, 16'h0);
    chk("rst_valid", rd_valid, 1'b0);
    chk("rst_zero_a", zero_a, 1'b1);
    chk("rst_zero_b", zero_b, 1'b1);
    chk("rst_wrap", wrap, 1'b0);

    // 1: first read after reset
    rst = 1'b1;
    rd(1'b1, 3'd0, 3'd7);
    tick();
    chk("t1_dout_a", data_out_a, 16'h0);
    chk("t1_dout_b", data_out_b, 16'h0);
    chk("t1_valid", rd_valid, 1'b1);
    chk("t1_zero_a", zero_a, 1'b1);
    chk("t1_zero_b", zero_b, 1'b1);
    chk("t1_wrap", wrap, 1'b0);

    // 2: load then read, ignored data_in when wr_en=0
    wr(1'b1, 2'b00, 3'd3, 16'h3333);
    rd(1'b0, 3'd0, 3'd0);
    tick();
    chk("t2_valid_low", rd_valid, 1'b0);
    wr(1'b0, 2'b00, 3'd3, 16'h333F);
    rd(1'b1, 3'd3, 3'd0);
    tick();
    chk("t2_dout_a", data_out_a, 16'h3333);
    chk("t2_zero_a", zero_a, 1'b0);
    tick();
    chk("t2_no_write", data_out_a, 16'h3333);

    // 3: same-cycle write and read on both ports
    wr(1'b1, 2'b00, 3'd5, 16'hABCD);
    rd(1'b1, 3'd5, 3'd5);
    tick();
    chk("t3_bypass_a", data_out_a, 16'hABCD);
    chk("t3_bypass_b", data_out_b, 16'hABCD);

    // 4: wrap on inc and dec, none on clear
    wr(1'b1, 2'b00, 3'd2, 16'hFFFF);
    rd(1'b0, 3'd0, 3'd0);
    tick();
    chk("t4_load_wrap", wrap, 1'b0);
    wr(1'b1, 2'b01, 3'd2, 16'h0);
    rd(1'b1, 3'd2, 3'd5);
    tick();
    chk("t4_inc_val", data_out_a, 16'h0000);
    chk("t4_inc_wrap", wrap, 1'b1);
    wr(1'b0, 2'b01, 3'd2, 16'h0);
    tick();
    chk("t4_wrap_1cyc", wrap, 1'b0);
    wr(1'b1, 2'b10, 3'd2, 16'h0);
    tick();
    chk("t4_dec_val", data_out_a, 16'hFFFF);
    chk("t4_dec_wrap", wrap, 1'b1);
    wr(1'b1, 2'b11, 3'd2, 16'h0);
    tick();
    chk("t4_clr_val", data_out_a, 16'h0000);
    chk("t4_clr_wrap", wrap, 1'b0);
    chk("t4_clr_zero", zero_a, 1'b1);

    // 5: decrement bypassed to read port
    wr(1'b1, 2'b00, 3'd1, 16'h0001);
    rd(1'b0, 3'd0, 3'd0);
    tick();
    wr(1'b1, 2'b10, 3'd1, 16'h0);
    rd(1'b1, 3'd1, 3'd3);
    tick();
    chk("t5_dec_a", data_out_a, 16'h0000);
    chk("t5_zero_a", zero_a, 1'b1);
    chk("t5_no_wrap", wrap, 1'b0);
    chk("t5_dout_b", data_out_b, 16'h3333);

    // read hold while rd_en=0
    wr(1'b0, 2'b00, 3'd0, 16'h0);
    rd(1'b1, 3'd5, 3'd3);
    tick();
    wr(1'b1, 2'b00, 3'd5, 16'h0000);
    rd(1'b0, 3'd5, 3'd3);
    tick();
    chk("hold_a", data_out_a, 16'hABCD);
    chk("hold_b", data_out_b, 16'h3333);
    chk("hold_valid", rd_valid, 1'b0);

    // 6: async reset between edges with a pending write
    wr(1'b1, 2'b00, 3'd4, 16'h1234);
    rd(1'b1, 3'd3, 3'd3);
    #3;
    rst = 1'b0;
    #1;
    chk("t6_async_a", data_out_a, 16'h0);
    chk("t6_async_b", data_out_b, 16'h0);
    chk("t6_async_zero", zero_b, 1'b1);
    tick();
    rst = 1'b1;
    wr(1'b0, 2'b00, 3'd0, 16'h0);
    rd(1'b1, 3'd4, 3'd3);
    tick();
    chk("t6_reg4", data_out_a, 16'h0);
    chk("t6_reg3", data_out_b, 16'h0);
    chk("t6_valid", rd_valid, 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
